ptvm_vend_ctrl: RTL and testbench
=================================

// Module: ptvm_vend_ctrl
// PURPOSE
//  Parametrised successor to the single-product vending FSM: multi-product
//  vending controller with credit accumulation, selection, cancel/refund,
//  and serial change dispensing (one coin per cycle). Sits between the coin
//  acceptor (3-bit coin code) and the product/change dispensers.
//  Coin codes (value in nickel units): 0=none, 1=NICKEL(1), 2=DIME(2),
//  3=NICKEL_DIME(3), 4=DIME_DIME(4), 5=QUARTER(5), 6/7=invalid (rejected).
// PARAMETERS
//  NUM_PROD   4                      number of products
//  SEL_W      2                      product select width, >= clog2(NUM_PROD)
//  CREDIT_W   8                      credit register width (nickel units)
//  MAX_CREDIT 20                     credit ceiling in nickel units (100c)
//  PRICE_LIST {8'd5,8'd4,8'd3,8'd2}  packed 8-bit prices; product 0 in LSB
// PORTS
//  clock       in   1         rising-edge clock
//  reset       in   1         asynchronous, active-high
//  coin        in   3         coin code; nonzero = one coin this cycle
//  sel         in   SEL_W     product index
//  sel_valid   in   1         purchase request for sel
//  cancel      in   1         refund all credit
//  vend        out  1         one-cycle dispense pulse
//  vend_id     out  SEL_W     product dispensed; valid while vend=1
//  change      out  3         coin code returned this cycle (0=none)
//  coin_reject out  1         one-cycle pulse: coin returned unaccepted
//  credit      out  CREDIT_W  current credit, nickel units
//  state       out  3         FSM state
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, credit=0, vend=0, vend_id=0,
//    change=0, coin_reject=0. Reset mid-operation aborts; credit is lost.
//  - States: IDLE=0, CREDIT=1, VEND=2, CHANGE=3, REFUND=4.
//  - IDLE/CREDIT, valid coin: credit += value next edge; IDLE->CREDIT.
//    If credit+value > MAX_CREDIT, or code 6/7: coin_reject=1 next cycle,
//    credit unchanged.
//  - CREDIT, sel_valid, no coin, no cancel, sel<NUM_PROD,
//    credit >= PRICE[sel]: next edge state=VEND, vend=1, vend_id=sel,
//    credit -= PRICE[sel]. Insufficient credit or sel>=NUM_PROD: ignored.
//  - Coin and sel_valid in the same cycle: coin accepted, sel ignored
//    (requester must re-assert).
//  - cancel in CREDIT: -> REFUND; wins over sel_valid and coin (coin rejected).
//    cancel in IDLE: no effect.
//  - VEND: one cycle. Then credit>0 -> CHANGE, else -> IDLE.
//  - CHANGE/REFUND: each cycle emit largest coin <= credit (DIME if >=2,
//    else NICKEL) on change; credit decrements by its value. When credit
//    reaches 0, change=0 and state->IDLE on the following edge.
//  - Coins arriving in VEND/CHANGE/REFUND: coin_reject=1; sel_valid and
//    cancel ignored.
//  - Credit never exceeds MAX_CREDIT and never wraps below 0.
// CONFIGURATION
//  PTVM_QUARTER_CHANGE_EN defined: change/refund emits QUARTER (5) whenever
//    credit >= 5 before trying DIME/NICKEL.
//  Not defined: change uses DIME/NICKEL only; code 5 never appears on change.
// TESTING
//  1. Assert reset mid-CHANGE -> state=0, credit=0, change=0, vend=0
//     immediately, without waiting for a clock edge.
//  2. QUARTER, then sel=2 sel_valid -> vend=1 for 1 cycle, vend_id=2,
//     then change=1 (NICKEL) for 1 cycle, then state=IDLE, credit=0.
//  3. NICKEL x4, sel=3 -> no vend, credit=4; NICKEL, sel=3 -> vend=1,
//     no change, state back to IDLE.
//  4. DIME x3, cancel -> change=2,2,2 on 3 cycles, credit 6->4->2->0,
//     vend never asserted.
//  5. QUARTER x4 (credit=20), NICKEL -> coin_reject=1, credit stays 20;
//     coin=6 in IDLE -> coin_reject=1, credit 0.
//  6. QUARTER x3, sel=0 (price 2), remainder 13 -> macro on: change
//     5,5,2,1; macro off: change 2,2,2,2,2,2,1.

Source files
------------

// File: rtl/ptvm_vend_ctrl.sv
// ptvm_vend_ctrl -- multi-product vending controller.
//
// Accumulates credit from a 3-bit coin acceptor and vends one of NUM_PROD
// products when credit covers its price. Remaining credit, or all credit
// after a cancel, is paid back one coin per cycle on the change port.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-high; clears state and credit
//   coin         coin code (0 none, 1..5 valid, 6/7 invalid)
//   sel          product index
//   sel_valid    purchase request for sel
//   cancel       refund all credit (only honoured in CREDIT)
//   vend         one-cycle dispense pulse
//   vend_id      product dispensed, valid while vend=1
//   change       coin code paid back this cycle (0 = none)
//   coin_reject  one-cycle pulse: inserted coin returned unaccepted
//   credit       current credit in nickel units
//   state        FSM state (IDLE=0 CREDIT=1 VEND=2 CHANGE=3 REFUND=4)
//
// Build option:
//   PTVM_QUARTER_CHANGE_EN  when defined, change/refund pays QUARTERs first;
//                           otherwise only DIMEs and NICKELs are returned.
module ptvm_vend_ctrl #(
  parameter int NUM_PROD   = 4,
  parameter int SEL_W      = 2,
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 20,
  parameter logic [8*NUM_PROD-1:0] PRICE_LIST = {8'd5, 8'd4, 8'd3, 8'd2}
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [2:0]          coin,
  input  logic [SEL_W-1:0]    sel,
  input  logic                sel_valid,
  input  logic                cancel,
  output logic                vend,
  output logic [SEL_W-1:0]    vend_id,
  output logic [2:0]          change,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CREDIT = 3'd1,
    VEND   = 3'd2,
    CHANGE = 3'd3,
    REFUND = 3'd4
  } state_t;

  state_t st;

  // Nickel value of a coin code; invalid codes map to 0.
  function automatic logic [2:0] coin_value(input logic [2:0] code);
    logic [2:0] v;
    v = 3'd0;
    if (code >= 3'd1 && code <= 3'd5) v = code;
    return v;
  endfunction

  // Price of a product; out-of-range indices return 0 (never used to vend).
  function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] idx);
    logic [CREDIT_W-1:0] p;
    p = '0;
    for (int i = 0; i < NUM_PROD; i++) begin
      if (i == int'(idx)) p = CREDIT_W'(PRICE_LIST[i*8 +: 8]);
    end
    return p;
  endfunction

  // Largest returnable coin not exceeding the remaining credit. For the
  // codes used here (1, 2, 5) the code equals its nickel value.
  function automatic logic [2:0] change_coin(input logic [CREDIT_W-1:0] c);
    logic [2:0] code;
    code = 3'd0;
`ifdef PTVM_QUARTER_CHANGE_EN
    if (c >= CREDIT_W'(5))      code = 3'd5;
    else if (c >= CREDIT_W'(2)) code = 3'd2;
    else if (c >= CREDIT_W'(1)) code = 3'd1;
`else
    if (c >= CREDIT_W'(2))      code = 3'd2;
    else if (c >= CREDIT_W'(1)) code = 3'd1;
`endif
    return code;
  endfunction

  logic [2:0]          val;
  logic [CREDIT_W:0]   sum;
  logic                coin_ok;
  logic                sel_ok;
  logic [CREDIT_W-1:0] price;
  logic [2:0]          chg;

  always_comb begin
    val     = coin_value(coin);
    // One extra bit so the ceiling test cannot wrap.
    sum     = {1'b0, credit} + (CREDIT_W+1)'(val);
    coin_ok = (val != 3'd0) && (sum <= (CREDIT_W+1)'(MAX_CREDIT));
    sel_ok  = int'(sel) < NUM_PROD;
    price   = price_of(sel);
    chg     = change_coin(credit);
  end

  assign state = st;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st          <= IDLE;
      credit      <= '0;
      vend        <= 1'b0;
      vend_id     <= '0;
      change      <= 3'd0;
      coin_reject <= 1'b0;
    end else begin
      vend        <= 1'b0;
      change      <= 3'd0;
      coin_reject <= 1'b0;
      case (st)
        IDLE, CREDIT: begin
          if (st == CREDIT && cancel) begin
            // Cancel beats any coin or selection presented alongside it.
            st <= REFUND;
            if (coin != 3'd0) coin_reject <= 1'b1;
          end else if (coin != 3'd0) begin
            // A coin always takes priority over a selection this cycle.
            if (coin_ok) begin
              credit <= sum[CREDIT_W-1:0];
              st     <= CREDIT;
            end else begin
              coin_reject <= 1'b1;
            end
          end else if (st == CREDIT && sel_valid && sel_ok && credit >= price) begin
            st      <= VEND;
            vend    <= 1'b1;
            vend_id <= sel;
            credit  <= credit - price;
          end
        end
        VEND: begin
          if (coin != 3'd0) coin_reject <= 1'b1;
          st <= (credit != '0) ? CHANGE : IDLE;
        end
        CHANGE, REFUND: begin
          if (coin != 3'd0) coin_reject <= 1'b1;
          if (credit != '0) begin
            change <= chg;
            credit <= credit - CREDIT_W'(chg);
          end else begin
            st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ptvm_vend_ctrl.sv
// Directed testbench for ptvm_vend_ctrl (default parameters, prices 2/3/4/5).
module tb_ptvm_vend_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] coin;
  logic [1:0] sel;
  logic       sel_valid;
  logic       cancel;
  logic       vend;
  logic [1:0] vend_id;
  logic [2:0] change;
  logic       coin_reject;
  logic [7:0] credit;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  ptvm_vend_ctrl dut (
    .clock(clock), .reset(reset), .coin(coin), .sel(sel),
    .sel_valid(sel_valid), .cancel(cancel), .vend(vend), .vend_id(vend_id),
    .change(change), .coin_reject(coin_reject), .credit(credit), .state(state)
  );

  always #5 clock = ~clock;

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    coin = 3'd0; sel = 2'd0; sel_valid = 1'b0; cancel = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic insert(input logic [2:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      coin = c;
      tick();
    end
    coin = 3'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    checks++;
    if ({state, credit, vend, vend_id, change, coin_reject} !== {3'd0, 8'd0, 1'b0, 2'd0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: state=%0d credit=%0d vend=%b id=%0d change=%0d rej=%b, required all zero",
               state, credit, vend, vend_id, change, coin_reject);
    end
    tick();
    reset = 1'b0;
    // Cancel in IDLE has no effect.
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    checks++;
    if (state !== 3'd0 || change !== 3'd0) begin
      errors++;
      $display("FAIL cancel_idle: state=%0d change=%0d, required 0 0", state, change);
    end
  endtask

  task automatic test_vend_with_change();
    apply_reset();
    insert(3'd5, 1);
    checks++;
    if (state !== 3'd1 || credit !== 8'd5) begin
      errors++;
      $display("FAIL quarter_credit: state=%0d credit=%0d, required 1 5", state, credit);
    end
    sel = 2'd2; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    checks++;
    if (vend !== 1'b1 || vend_id !== 2'd2 || state !== 3'd2 || credit !== 8'd1) begin
      errors++;
      $display("FAIL vend_sel2: vend=%b id=%0d state=%0d credit=%0d, required 1 2 2 1",
               vend, vend_id, state, credit);
    end
    tick();
    checks++;
    if (vend !== 1'b0 || state !== 3'd3 || change !== 3'd0) begin
      errors++;
      $display("FAIL vend_pulse_end: vend=%b state=%0d change=%0d, required 0 3 0", vend, state, change);
    end
    tick();
    checks++;
    if (change !== 3'd1 || credit !== 8'd0) begin
      errors++;
      $display("FAIL change_nickel: change=%0d credit=%0d, required 1 0", change, credit);
    end
    tick();
    checks++;
    if (change !== 3'd0 || state !== 3'd0 || credit !== 8'd0) begin
      errors++;
      $display("FAIL back_to_idle: change=%0d state=%0d credit=%0d, required 0 0 0", change, state, credit);
    end
  endtask

  task automatic test_exact_price();
    apply_reset();
    insert(3'd1, 4);
    sel = 2'd3; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    checks++;
    if (vend !== 1'b0 || credit !== 8'd4 || state !== 3'd1) begin
      errors++;
      $display("FAIL insufficient: vend=%b credit=%0d state=%0d, required 0 4 1", vend, credit, state);
    end
    // Coin and selection together: coin taken, selection dropped.
    coin = 3'd1; sel_valid = 1'b1;
    tick();
    coin = 3'd0;
    checks++;
    if (vend !== 1'b0 || credit !== 8'd5 || state !== 3'd1) begin
      errors++;
      $display("FAIL coin_and_sel: vend=%b credit=%0d state=%0d, required 0 5 1", vend, credit, state);
    end
    tick();
    sel_valid = 1'b0;
    checks++;
    if (vend !== 1'b1 || vend_id !== 2'd3 || credit !== 8'd0 || state !== 3'd2) begin
      errors++;
      $display("FAIL exact_vend: vend=%b id=%0d credit=%0d state=%0d, required 1 3 0 2",
               vend, vend_id, credit, state);
    end
    // A coin during VEND is returned.
    coin = 3'd2;
    tick();
    coin = 3'd0;
    checks++;
    if (vend !== 1'b0 || state !== 3'd0 || change !== 3'd0 || coin_reject !== 1'b1 || credit !== 8'd0) begin
      errors++;
      $display("FAIL exact_idle: vend=%b state=%0d change=%0d rej=%b credit=%0d, required 0 0 0 1 0",
               vend, state, change, coin_reject, credit);
    end
  endtask

  task automatic test_cancel_refund();
    logic [7:0] exp_credit [3];
    int vend_seen;
    exp_credit = '{8'd4, 8'd2, 8'd0};
    vend_seen = 0;
    apply_reset();
    insert(3'd2, 3);
    // Cancel with a coin: cancel wins and the coin is rejected.
    cancel = 1'b1; coin = 3'd1; sel = 2'd0; sel_valid = 1'b1;
    tick();
    cancel = 1'b0; coin = 3'd0; sel_valid = 1'b0;
    checks++;
    if (state !== 3'd4 || credit !== 8'd6 || coin_reject !== 1'b1 || vend !== 1'b0) begin
      errors++;
      $display("FAIL cancel_enter: state=%0d credit=%0d rej=%b vend=%b, required 4 6 1 0",
               state, credit, coin_reject, vend);
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 0) coin = 3'd1;  // coin while refunding is rejected
      tick();
      coin = 3'd0;
      if (vend) vend_seen++;
      checks++;
      if (change !== 3'd2 || credit !== exp_credit[i] || coin_reject !== (i == 0)) begin
        errors++;
        $display("FAIL refund_step%0d: change=%0d credit=%0d rej=%b, required 2 %0d %b",
                 i, change, credit, coin_reject, exp_credit[i], (i == 0));
      end
    end
    tick();
    if (vend) vend_seen++;
    checks++;
    if (change !== 3'd0 || state !== 3'd0 || vend_seen != 0) begin
      errors++;
      $display("FAIL refund_done: change=%0d state=%0d vends=%0d, required 0 0 0", change, state, vend_seen);
    end
  endtask

  task automatic test_ceiling_and_invalid();
    apply_reset();
    insert(3'd5, 4);
    checks++;
    if (credit !== 8'd20) begin
      errors++;
      $display("FAIL credit_max: credit=%0d, required 20", credit);
    end
    insert(3'd1, 1);
    checks++;
    if (coin_reject !== 1'b1 || credit !== 8'd20) begin
      errors++;
      $display("FAIL over_max: rej=%b credit=%0d, required 1 20", coin_reject, credit);
    end
    tick();
    checks++;
    if (coin_reject !== 1'b0) begin
      errors++;
      $display("FAIL reject_pulse: rej=%b, required 0", coin_reject);
    end
    apply_reset();
    insert(3'd6, 1);
    checks++;
    if (coin_reject !== 1'b1 || credit !== 8'd0 || state !== 3'd0) begin
      errors++;
      $display("FAIL invalid6: rej=%b credit=%0d state=%0d, required 1 0 0", coin_reject, credit, state);
    end
    insert(3'd7, 1);
    checks++;
    if (coin_reject !== 1'b1 || credit !== 8'd0) begin
      errors++;
      $display("FAIL invalid7: rej=%b credit=%0d, required 1 0", coin_reject, credit);
    end
  endtask

  task automatic test_change_sequence();
`ifdef PTVM_QUARTER_CHANGE_EN
    logic [2:0] exp [4] = '{3'd5, 3'd5, 3'd2, 3'd1};
    int n = 4;
`else
    logic [2:0] exp [7] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1};
    int n = 7;
`endif
    int remaining;
    apply_reset();
    insert(3'd5, 3);
    sel = 2'd0; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    checks++;
    if (vend !== 1'b1 || vend_id !== 2'd0 || credit !== 8'd13) begin
      errors++;
      $display("FAIL vend_sel0: vend=%b id=%0d credit=%0d, required 1 0 13", vend, vend_id, credit);
    end
    tick();
    remaining = 13;
    for (int i = 0; i < n; i++) begin
      tick();
      remaining -= int'(exp[i]);
      checks++;
      if (change !== exp[i] || credit !== 8'(remaining) || state !== 3'd3) begin
        errors++;
        $display("FAIL change_step%0d: change=%0d credit=%0d state=%0d, required %0d %0d 3",
                 i, change, credit, state, exp[i], remaining);
      end
    end
    tick();
    checks++;
    if (change !== 3'd0 || state !== 3'd0) begin
      errors++;
      $display("FAIL change_done: change=%0d state=%0d, required 0 0", change, state);
    end
  endtask

  task automatic test_reset_mid_change();
    apply_reset();
    insert(3'd5, 2);
    sel = 2'd0; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (state !== 3'd3 || change !== 3'd2 || credit !== 8'd6) begin
      errors++;
      $display("FAIL pre_reset: state=%0d change=%0d credit=%0d, required 3 2 6", state, change, credit);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || credit !== 8'd0 || change !== 3'd0 || vend !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: state=%0d credit=%0d change=%0d vend=%b, required 0 0 0 0",
               state, credit, change, vend);
    end
    #1;
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vend_with_change();
    test_exact_price();
    test_cancel_refund();
    test_ceiling_and_invalid();
    test_change_sequence();
    test_reset_mid_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
